dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Handshaked data-memory responder serving the load/store requests that the datapath issues on its memory port (address, write data, write enable, funct3-style mode).
- Replaces the zero-latency dmem model with a programmable-wait-state slave.
- Emits a stall to hold the pipeline's M stage until each access completes.
- Word-organised internal storage; byte/half/word lanes; load sign/zero extension.

Parameters:
- DEPTH_WORDS, 1024, storage size in 32-bit words; power of two.
- WAIT_STATES, 2, extra cycles between request acceptance and response; range 0-15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  initiator request; held until rsp_valid.
- req_we  in  1  1 = store, 0 = load.
- req_mode  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (funct3 encoding).
- req_adrs  in  32  byte address.
- req_wd  in  32  store data, right-aligned.
- req_ready  out  1  responder can accept a request this cycle.
- rsp_valid  out  1  one-cycle pulse: access complete.
- rsp_rd  out  32  load data, extended; 0 for stores.
- rsp_err  out  1  error flag, qualified by rsp_valid.
- stall  out  1  combinational req_valid & ~rsp_valid; drives stall_M.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, wait counter=0, rsp_valid=0, rsp_rd=0, rsp_err=0.
  - Storage contents are not cleared.
- States:
  - IDLE: req_ready=1.
  - WAIT: req_ready=0.
  - RESP: req_ready=0, rsp_valid=1.
- IDLE:
  - If req_valid, latch we/mode/adrs/wd and load counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, else RESP.
- WAIT: decrement counter; go to RESP on the edge when counter==1.
- Commit edge (entering RESP):
  - Store: byte-enabled write of the selected lanes.
  - Load: rsp_rd registered.
- RESP: lasts exactly one cycle, then IDLE.
- Latency: acceptance edge to rsp_valid high is WAIT_STATES+1 cycles.
- Back-to-back: the initiator must present the next request after RESP. Peak throughput is one access per WAIT_STATES+2 cycles.
- Addressing:
  - Word index = req_adrs[log2(DEPTH_WORDS)+1:2]; upper bits are ignored, so out-of-range addresses wrap modulo size.
  - Lane = adrs[1:0]. Byte selects lane adrs[1:0]; half selects lanes {adrs[1],0}+1..0.
- Loads:
  - B/H sign-extend; BU/HU zero-extend; W returns the full word.
- Stores:
  - B writes 1 lane from req_wd[7:0]; H writes 2 lanes from req_wd[15:0]; W writes 4.
  - Unselected lanes are unchanged.
- Invalid modes (011, 110, 111): store suppressed, rsp_rd=0, rsp_err=1.
- BU/HU with req_we=1 are treated as B/H stores.
- req_valid dropped mid-access is a protocol violation. The access still completes and the rsp_valid pulse is still produced.
- Reset mid-access: the access is aborted. A store not yet committed leaves storage untouched.
- req_* changes after acceptance are ignored, since latched copies are used.

Optional Feature:
- Macro: DMEM_MISALIGN_EN.
- Defined:
  - H with adrs[0]=1, or W with adrs[1:0]!=0, is misaligned.
  - Store suppressed, rsp_rd=0, rsp_err=1 with rsp_valid.
- Undefined:
  - Offending low address bits are forced to 0 (H aligns to the halfword, W to the word).
  - Access proceeds; rsp_err is set only for invalid modes.

Test Plan:
- Reset with reset=0 mid-WAIT of a SW to 0x10, then release, then LW 0x10 -> returns the pre-test value; rsp_valid=0 and req_ready=1 on release.
- WAIT_STATES=2: SW 0xDEADBEEF @0x20, then LW @0x20 -> rsp_valid 3 cycles after each acceptance; rd=0xDEADBEEF; stall high for 3 cycles per access.
- SB 0x80 @0x21, then LB @0x21 -> 0xFFFFFF80; LBU @0x21 -> 0x00000080; LW @0x20 -> 0xDEAD80EF.
- SH 0x8001 @0x22, then LH -> 0xFFFF8001; LHU -> 0x00008001. WAIT_STATES=0: rsp_valid on the cycle after acceptance.
- Address wrap: SW 0x12345678 @ DEPTH_WORDS*4+4, then LW @0x4 -> 0x12345678. Mode 011 -> rsp_err=1, storage unchanged.
- DMEM_MISALIGN_EN: LW @0x22 -> rsp_err=1, rd=0. Without it: LW @0x22 returns the word at 0x20, rsp_err=0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked data-memory slave with programmable wait states.
// Accepts one load/store at a time, holds it for WAIT_STATES cycles, then
// commits it and pulses rsp_valid for one cycle. Storage is word-organised
// with byte/half/word lanes and sign/zero extension on loads.
// Optional build macro: DMEM_MISALIGN_EN. When defined, misaligned H/W
// accesses are rejected with rsp_err. When undefined, they are aligned down.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_mode,
    input  logic [31:0] req_adrs,
    input  logic [31:0] req_wd,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rd,
    output logic        rsp_err,
    output logic        stall
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t         state_reg;
    logic [3:0]     cnt_reg;
    logic           we_reg;
    logic [2:0]     mode_reg;
    logic [AW+1:0]  adrs_reg;
    logic [31:0]    wd_reg;

    logic [31:0]    mem [DEPTH_WORDS];

    // The access being committed: live request when committing straight from
    // IDLE (zero wait states), latched copy otherwise.
    logic           acc_we;
    logic [2:0]     acc_mode;
    logic [AW+1:0]  acc_adrs;
    logic [31:0]    acc_wd;
    logic           go_resp;
    logic           mode_ok;
    logic           misalign;
    logic           acc_err;
    logic [1:0]     lane;
    logic [AW-1:0]  idx;
    logic [3:0]     be;
    logic [31:0]    wdata;
    logic [31:0]    mem_word;
    logic [31:0]    shifted;
    logic [31:0]    load_data;
    logic           store_en;

    // Address bits above the storage size are intentionally ignored (wrap).
    logic unused_adrs_bits;
    assign unused_adrs_bits = ^req_adrs[31:AW+2];

    // Select the access source and decode mode/alignment
    always_comb begin
        if (state_reg == S_IDLE) begin
            acc_we   = req_we;
            acc_mode = req_mode;
            acc_adrs = req_adrs[AW+1:0];
            acc_wd   = req_wd;
        end else begin
            acc_we   = we_reg;
            acc_mode = mode_reg;
            acc_adrs = adrs_reg;
            acc_wd   = wd_reg;
        end

        go_resp = ((state_reg == S_IDLE) && req_valid && (WS == 4'd0)) ||
                  ((state_reg == S_WAIT) && (cnt_reg <= 4'd1));

        mode_ok  = !((acc_mode == 3'b011) || (acc_mode[2:1] == 2'b11));
        misalign = ((acc_mode[1:0] == 2'b01) && acc_adrs[0]) ||
                   ((acc_mode[1:0] == 2'b10) && (acc_adrs[1:0] != 2'b00));
`ifdef DMEM_MISALIGN_EN
        acc_err = !mode_ok || misalign;
        lane    = acc_adrs[1:0];
`else
        acc_err = !mode_ok;
        case (acc_mode[1:0])
            2'b01:   lane = {acc_adrs[1], 1'b0};
            2'b10:   lane = 2'b00;
            default: lane = acc_adrs[1:0];
        endcase
`endif
        idx      = acc_adrs[AW+1:2];
        store_en = go_resp && acc_we && !acc_err && reset;
    end

    // Per-lane byte enables and right-aligned store data replicated onto lanes
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            always_comb begin
                case (acc_mode[1:0])
                    2'b00: begin
                        be[gi]           = (lane == 2'(gi));
                        wdata[8*gi +: 8] = acc_wd[7:0];
                    end
                    2'b01: begin
                        be[gi]           = (lane[1] == 1'(gi / 2));
                        wdata[8*gi +: 8] = acc_wd[8*(gi % 2) +: 8];
                    end
                    default: begin
                        be[gi]           = 1'b1;
                        wdata[8*gi +: 8] = acc_wd[8*gi +: 8];
                    end
                endcase
            end
        end
    endgenerate

    // Load lane extraction and sign/zero extension
    always_comb begin
        mem_word = mem[idx];
        shifted  = mem_word >> {lane, 3'b000};
        case (acc_mode[1:0])
            2'b00:   load_data = {{24{~acc_mode[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{~acc_mode[2] & shifted[15]}}, shifted[15:0]};
            2'b10:   load_data = mem_word;
            default: load_data = 32'h0;
        endcase
    end

    // Byte-enabled storage write on the commit edge; contents survive reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (store_en && be[i]) begin
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Control FSM: accept, count wait states, commit and pulse the response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            mode_reg  <= 3'b000;
            adrs_reg  <= '0;
            wd_reg    <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_rd    <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= go_resp;
            if (go_resp) begin
                rsp_rd  <= (acc_we || acc_err) ? 32'h0 : load_data;
                rsp_err <= acc_err;
            end
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        we_reg    <= req_we;
                        mode_reg  <= req_mode;
                        adrs_reg  <= req_adrs[AW+1:0];
                        wd_reg    <= req_wd;
                        cnt_reg   <= WS;
                        state_reg <= (WS == 4'd0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_reg <= 4'd1) begin
                        cnt_reg   <= 4'd0;
                        state_reg <= S_RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                S_RESP: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_reg == S_IDLE);
    assign stall     = req_valid & ~rsp_valid;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: randomized loads/stores scored against a
// byte-addressed reference memory. The driver pushes expected responses into
// a queue; a monitor pops and compares whenever rsp_valid is seen.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int WS    = 2;
    localparam int MB    = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_mode = 3'b000;
    logic [31:0] req_adrs = 32'h0;
    logic [31:0] req_wd = 32'h0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rd;
    logic        rsp_err;
    logic        stall;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_mode(req_mode),
        .req_adrs(req_adrs), .req_wd(req_wd),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rd(rsp_rd),
        .rsp_err(rsp_err), .stall(stall)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [7:0]  mbytes [MB];
    logic [32:0] exp_q [$];   // {err, rd}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: byte-addressed memory, little endian, size = 1<<mode[1:0]
    function automatic logic [32:0] model(input logic we, input logic [2:0] mode,
                                          input logic [31:0] adrs, input logic [31:0] wd);
        int size;
        logic [31:0] a;
        logic [63:0] v;
        if (mode == 3'd3 || mode == 3'd6 || mode == 3'd7) return {1'b1, 32'h0};
        size = 1 << mode[1:0];
`ifdef DMEM_MISALIGN_EN
        if ((adrs % 32'(size)) != 0) return {1'b1, 32'h0};
`endif
        a = adrs - (adrs % 32'(size));
        if (we) begin
            for (int k = 0; k < size; k++) mbytes[(a + 32'(k)) % 32'(MB)] = wd[8*k +: 8];
            return {1'b0, 32'h0};
        end
        v = 64'h0;
        for (int k = 0; k < size; k++) v = v | (64'(mbytes[(a + 32'(k)) % 32'(MB)]) << (8*k));
        if (!mode[2] && v[8*size-1]) v = v | ~((64'd1 << (8*size)) - 64'd1);
        return {1'b0, v[31:0]};
    endfunction

    // Drive one access (starting at a negedge), check handshake timing
    task automatic access(input logic we, input logic [2:0] mode,
                          input logic [31:0] adrs, input logic [31:0] wd);
        int cycles;
        exp_q.push_back(model(we, mode, adrs, wd));
        req_we = we; req_mode = mode; req_adrs = adrs; req_wd = wd; req_valid = 1'b1;
        #1;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        cycles = 0;
        forever begin
            @(negedge clk);
            cycles++;
            if (rsp_valid) break;
            chk("stall_wait", 32'(stall), 32'd1);
            // Post-acceptance changes must be ignored
            req_we = 1'($urandom); req_mode = 3'($urandom); req_adrs = $urandom; req_wd = $urandom;
            if (cycles > 40) break;
        end
        chk("latency", 32'(cycles), 32'(WS + 1));
        chk("stall_rsp", 32'(stall), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: compare each response against the head of the scoreboard
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                $display("rsp rd=%h err=%0d exp rd=%h err=%0d", rsp_rd, rsp_err, e[31:0], e[32]);
                chk("rsp_rd", rsp_rd, e[31:0]);
                chk("rsp_err", 32'(rsp_err), 32'(e[32]));
            end
        end
    end

    initial begin
        logic [2:0] m;
        int r;
        repeat (3) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rd", rsp_rd, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        reset = 1'b1;
        @(negedge clk);

        // Fill every word so the model knows all contents
        for (int w = 0; w < DEPTH; w++) access(1'b1, 3'b010, 32'(w * 4), $urandom);

        // Reset mid-WAIT of a store: storage must be untouched
        req_we = 1'b1; req_mode = 3'b010; req_adrs = 32'h10; req_wd = 32'h11111111; req_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("abort_rsp_valid2", 32'(rsp_valid), 32'd0);
        access(1'b0, 3'b010, 32'h10, 32'h0);

        // Directed cases
        access(1'b1, 3'b010, 32'h20, 32'hDEADBEEF);
        access(1'b0, 3'b010, 32'h20, 32'h0);
        access(1'b1, 3'b000, 32'h21, 32'h00000080);
        access(1'b0, 3'b000, 32'h21, 32'h0);
        access(1'b0, 3'b100, 32'h21, 32'h0);
        access(1'b0, 3'b010, 32'h20, 32'h0);
        access(1'b1, 3'b001, 32'h22, 32'h00008001);
        access(1'b0, 3'b001, 32'h22, 32'h0);
        access(1'b0, 3'b101, 32'h22, 32'h0);
        access(1'b1, 3'b010, 32'(DEPTH * 4 + 4), 32'h12345678);
        access(1'b0, 3'b010, 32'h4, 32'h0);
        access(1'b1, 3'b011, 32'h20, 32'hFFFFFFFF);
        access(1'b0, 3'b010, 32'h20, 32'h0);
        access(1'b0, 3'b010, 32'h22, 32'h0);
        access(1'b1, 3'b101, 32'h31, 32'hA5A5C3C3);
        access(1'b0, 3'b010, 32'h30, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1: m = 3'b000;
                2, 3: m = 3'b001;
                4, 5: m = 3'b010;
                6:    m = 3'b100;
                7:    m = 3'b101;
                8:    m = 3'b011;
                default: m = ($urandom_range(0, 1) == 0) ? 3'b110 : 3'b111;
            endcase
            access(1'($urandom), m, $urandom, $urandom);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
